// File: rtl/promedio_muestras.sv
// Moving average over the last 2**N_LOG2 accepted ADC samples, with a three-state load pipeline.
// Optional frame check on the leading zero bits is enabled by defining PROMEDIO_ZERO_CHECK_EN.
module promedio_muestras #(
    parameter int N_LOG2 = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        listo_in,
    input  logic [3:0]  zeros_in,
    input  logic [11:0] dato_in,
    output logic [11:0] promedio,
    output logic        valido,
    output logic        lleno,
    output logic        sobrecarga,
    output logic        error_trama
);
    localparam int W = 1 << N_LOG2;
    localparam logic [N_LOG2:0] FULL = 1'b1 << N_LOG2;
    localparam logic [N_LOG2:0] LAST = FULL - 1'b1;

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] CARGA  = 2'd1;
    localparam logic [1:0] SALIDA = 2'd2;

    logic [1:0]         state;
    logic [11:0]        muestra;
    logic [11+N_LOG2:0] sum;
    logic [11:0]        mem [W];
    logic [N_LOG2-1:0]  ptr;
    logic [N_LOG2:0]    fill;
    logic               frame_ok;

`ifdef PROMEDIO_ZERO_CHECK_EN
    assign frame_ok = (zeros_in == 4'b0000);
`else
    logic unused_zeros;
    assign unused_zeros = ^zeros_in;
    assign frame_ok     = 1'b1;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            muestra     <= '0;
            sum         <= '0;
            ptr         <= '0;
            fill        <= '0;
            promedio    <= '0;
            valido      <= 1'b0;
            lleno       <= 1'b0;
            sobrecarga  <= 1'b0;
            error_trama <= 1'b0;
            for (int unsigned i = 0; i < W; i++) mem[i] <= '0;
        end else begin
            valido      <= 1'b0;
            error_trama <= 1'b0;
            case (state)
                IDLE: begin
                    if (listo_in) begin
                        if (frame_ok) begin
                            muestra <= dato_in;
                            state   <= CARGA;
                        end else begin
                            error_trama <= 1'b1;
                        end
                    end
                end
                CARGA: begin
                    if (listo_in) sobrecarga <= 1'b1;
                    // Running sum: evict the oldest entry and add the new sample in one step.
                    sum      <= sum - {{N_LOG2{1'b0}}, mem[ptr]} + {{N_LOG2{1'b0}}, muestra};
                    mem[ptr] <= muestra;
                    ptr      <= ptr + 1'b1;
                    if (fill != FULL) fill <= fill + 1'b1;
                    if (fill == LAST) lleno <= 1'b1;
                    state    <= SALIDA;
                end
                SALIDA: begin
                    if (listo_in) sobrecarga <= 1'b1;
                    promedio <= sum[11+N_LOG2:N_LOG2];
                    valido   <= 1'b1;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
